// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared master ids, priority-mode encodings and lock states for the memory bus
package riscv_bus_pkg;
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;
    localparam int PRIO_RR = 0;
    localparam int PRIO_FIXED = 1;
    typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} lock_state_t;
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: one-hot 2-way grant honouring lock ownership, round-robin or fixed priority
module bus_rr_pick
    import riscv_bus_pkg::*;
(
    input  logic        [1:0] req,
    input  logic              ptr,
    input  lock_state_t       lock_state,
    input  logic              fixed,
    output logic        [1:0] gnt
);
    always_comb begin
        gnt = lock_state == LOCK0 ? {1'b0, req[0]} :
              lock_state == LOCK1 ? {req[1], 1'b0} :
              req != 2'b11 ? req :
              (fixed || ptr == M_CPU) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the word memory bus between two masters with bus lock
// and tagged routing of fixed-latency read data.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);
    logic [1:0] req, gnt;
    logic ptr, gid;
    lock_state_t lock_state;
    logic [RD_LAT-1:0] tag_v, tag_id;
    logic [31:0] hold0, hold1;

    assign req = reset ? 2'b00 : {m1_req, m0_req};
    assign gid = gnt[1];
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    bus_rr_pick u_pick (
        .req(req),
        .ptr(ptr),
        .lock_state(lock_state),
        .fixed(PRIO_MODE == PRIO_FIXED),
        .gnt(gnt)
    );

    assign mem_addr = gnt[0] ? m0_addr : gnt[1] ? m1_addr : 32'd0;
    assign mem_wdata = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : 32'd0;
    assign mem_rstrb = gnt[0] ? !m0_we : gnt[1] & !m1_we;
    assign mem_wmask = (gnt[0] & m0_we) ? m0_wmask : (gnt[1] & m1_we) ? m1_wmask : 4'd0;

    // A locked owner is granted whenever it requests, so dropping its lock always releases the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= UNLOCKED;
            ptr <= M_CPU;
        end else begin
            case (lock_state)
                LOCK0: lock_state <= m0_lock ? LOCK0 : UNLOCKED;
                LOCK1: lock_state <= m1_lock ? LOCK1 : UNLOCKED;
                default: if (|gnt) begin
                    ptr <= !gid;
                    lock_state <= !(gid ? m1_lock : m0_lock) ? UNLOCKED : gid ? LOCK1 : LOCK0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_id <= '0;
            hold0 <= 32'd0;
            hold1 <= 32'd0;
        end else begin
            tag_v <= RD_LAT'({tag_v, mem_rstrb});
            tag_id <= RD_LAT'({tag_id, gid});
            if (m0_rvalid) hold0 <= mem_rdata;
            if (m1_rvalid) hold1 <= mem_rdata;
        end
    end

    assign m0_rvalid = !reset & tag_v[RD_LAT-1] & (tag_id[RD_LAT-1] == M_CPU);
    assign m1_rvalid = !reset & tag_v[RD_LAT-1] & (tag_id[RD_LAT-1] == M_AUX);
    assign m0_rdata = reset ? 32'd0 : m0_rvalid ? mem_rdata : hold0;
    assign m1_rdata = reset ? 32'd0 : m1_rvalid ? mem_rdata : hold1;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: three arbiter configurations driven by directed and random traffic,
// each checked cycle by cycle against a transaction-level model of grants, locks and read returns.
module tb_mem_bus_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic req [N][2], we [N][2], lock [N][2];
    logic [31:0] addr [N][2], wdata [N][2];
    logic [3:0] wmask [N][2];
    logic gnt [N][2], rvalid [N][2];
    logic [31:0] rdata [N][2];
    logic [31:0] mem_addr [N], mem_wdata [N], mem_rdata [N];
    logic mem_rstrb [N];
    logic [3:0] mem_wmask [N];

    function automatic int lat_of(int g);
        return g == 0 ? 1 : g == 1 ? 3 : 2;
    endfunction

    function automatic logic [31:0] init_word(int g, int k);
        return 32'hA500_0000 ^ (32'(g) << 16) ^ (32'(k) * 32'h0101_0101);
    endfunction

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int LAT = g == 0 ? 1 : g == 1 ? 3 : 2;
        mem_bus_arbiter #(.RD_LAT(LAT), .PRIO_MODE(g == 2 ? 1 : 0)) dut (
            .clk(clk), .reset(reset),
            .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
            .m0_wmask(wmask[g][0]), .m0_lock(lock[g][0]), .m0_gnt(gnt[g][0]),
            .m0_rvalid(rvalid[g][0]), .m0_rdata(rdata[g][0]),
            .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
            .m1_wmask(wmask[g][1]), .m1_lock(lock[g][1]), .m1_gnt(gnt[g][1]),
            .m1_rvalid(rvalid[g][1]), .m1_rdata(rdata[g][1]),
            .mem_addr(mem_addr[g]), .mem_rstrb(mem_rstrb[g]), .mem_wdata(mem_wdata[g]),
            .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata[g])
        );
        // Memory returns garbage when idle so misrouted or mistimed data cannot look right.
        logic [31:0] bmem [16];
        logic [31:0] pipe [4];
        logic boot = 1'b1;
        always @(posedge clk) begin
            pipe[0] <= mem_rstrb[g] ? bmem[mem_addr[g][5:2]] : $urandom;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            boot <= 1'b0;
            for (int k = 0; k < 16; k++) if (boot) bmem[k] <= init_word(g, k);
            for (int b = 0; b < 4; b++)
                if (mem_wmask[g][b]) bmem[mem_addr[g][5:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    typedef struct {int g; int due; int m; logic [31:0] d;} rsp_t;
    rsp_t q [$];
    int owner [N], ptr [N], expk [N];
    logic [31:0] mmem [N][16];
    logic [31:0] last [N][2];
    logic pend [N][2];
    int cyc, checks, errors;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < N; g++) begin
            int k;
            int s;
            logic v;
            logic [31:0] d;
            k = -1;
            if (!reset) begin
                if (owner[g] >= 0) k = req[g][owner[g]] ? owner[g] : -1;
                else if (req[g][0] && req[g][1]) k = (g == 2 || ptr[g] == 0) ? 0 : 1;
                else if (req[g][0]) k = 0;
                else if (req[g][1]) k = 1;
            end
            expk[g] = k;
            s = k < 0 ? 0 : k;
            chk($sformatf("g%0d gnt", g), {30'd0, gnt[g][1], gnt[g][0]}, k < 0 ? 32'd0 : 32'(1 << k));
            chk($sformatf("g%0d mem_addr", g), mem_addr[g], k < 0 ? 32'd0 : addr[g][s]);
            chk($sformatf("g%0d mem_wdata", g), mem_wdata[g], k < 0 ? 32'd0 : wdata[g][s]);
            chk($sformatf("g%0d mem_rstrb", g), 32'(mem_rstrb[g]), 32'(k >= 0 && !we[g][s]));
            chk($sformatf("g%0d mem_wmask", g), 32'(mem_wmask[g]),
                (k >= 0 && we[g][s]) ? 32'(wmask[g][s]) : 32'd0);
            for (int m = 0; m < 2; m++) begin
                v = 1'b0;
                d = last[g][m];
                foreach (q[i]) if (q[i].g == g && q[i].m == m && q[i].due == cyc) begin
                    v = 1'b1;
                    d = q[i].d;
                end
                if (reset) begin
                    v = 1'b0;
                    d = 32'd0;
                end
                chk($sformatf("g%0d m%0d_rvalid", g, m), 32'(rvalid[g][m]), 32'(v));
                chk($sformatf("g%0d m%0d_rdata", g, m), rdata[g][m], d);
                if (v) last[g][m] = d;
            end
        end
    endtask

    task automatic update_all();
        if (reset) begin
            q.delete();
            for (int g = 0; g < N; g++) begin
                owner[g] = -1;
                ptr[g] = 0;
                for (int m = 0; m < 2; m++) begin
                    last[g][m] = 32'd0;
                    pend[g][m] = 1'b0;
                end
            end
            return;
        end
        q = q.find(x) with (x.due > cyc);
        for (int g = 0; g < N; g++) begin
            int k;
            int o;
            k = expk[g];
            if (k >= 0 && !we[g][k]) q.push_back(rsp_t'{g, cyc + lat_of(g), k, mmem[g][addr[g][k][5:2]]});
            if (k >= 0 && we[g][k])
                for (int b = 0; b < 4; b++)
                    if (wmask[g][k][b]) mmem[g][addr[g][k][5:2]][8*b +: 8] = wdata[g][k][8*b +: 8];
            if (owner[g] < 0) begin
                if (k >= 0) begin
                    ptr[g] = 1 - k;
                    if (lock[g][k]) owner[g] = k;
                end
            end else begin
                o = owner[g];
                if (!lock[g][o] && (k == o || !req[g][o])) owner[g] = -1;
            end
            for (int m = 0; m < 2; m++) pend[g][m] = req[g][m] && k != m;
        end
    endtask

    task automatic step();
        #4;
        check_all();
        update_all();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic put(int m, logic r, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] k, logic l);
        for (int g = 0; g < N; g++) begin
            req[g][m] = r;
            we[g][m] = w;
            addr[g][m] = a;
            wdata[g][m] = d;
            wmask[g][m] = k;
            lock[g][m] = l;
        end
    endtask

    task automatic randomize_inputs();
        for (int g = 0; g < N; g++)
            for (int m = 0; m < 2; m++)
                if (!(pend[g][m] && $urandom_range(0, 19) != 0)) begin
                    req[g][m] = $urandom_range(0, 99) < 60;
                    we[g][m] = 1'($urandom_range(0, 1));
                    addr[g][m] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    wdata[g][m] = $urandom;
                    wmask[g][m] = 4'($urandom);
                    lock[g][m] = $urandom_range(0, 9) < 2;
                end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        for (int g = 0; g < N; g++) begin
            owner[g] = -1;
            ptr[g] = 0;
            for (int k = 0; k < 16; k++) mmem[g][k] = init_word(g, k);
            for (int m = 0; m < 2; m++) begin
                last[g][m] = 32'd0;
                pend[g][m] = 1'b0;
            end
        end
        reset = 1'b1;
        put(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        put(1, 1'b1, 1'b1, 32'h14, 32'h1234_5678, 4'hF, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) step();
        reset = 1'b0;
        put(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        put(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        put(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (4) step();
        put(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        put(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);
        repeat (4) step();
        put(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        put(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (4) step();
        put(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        step();
        put(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        put(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
        step();
        put(1, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        step();
        put(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        put(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        step();
        put(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (4) step();
        put(0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0);
        step();
        put(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        put(1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0);
        step();
        put(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (5) step();
        put(0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0);
        step();
        put(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (5) step();
        repeat (600) begin
            randomize_inputs();
            reset = $urandom_range(0, 149) == 0;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single-port word memory bus (byte-mask writes, fixed-latency reads) between the RISC-V processor (master 0) and a second requester such as a program loader or debug DMA (master 1). It sits between the masters and the memory/IO decode in `system`. It grants at most one command per cycle, routes read data back to the issuing master, and supports a bus lock for atomic read-modify-write sequences.

## Interface
Parameters:
- RD_LAT, 1, memory read latency in cycles from command to valid mem_rdata; legal range 1..4
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with master 0 highest

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mN_req  in  1  command pending; N = 0, 1; held with its fields stable until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data, already lane-aligned
- mN_wmask  in  4  byte enables; ignored for reads
- mN_lock  in  1  keep ownership after this command
- mN_gnt  out  1  command accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid pulse
- mN_rdata  out  32  read data; valid only while mN_rvalid is high
- mem_addr  out  32  granted address; 0 when idle
- mem_rstrb  out  1  read strobe
- mem_wdata  out  32  granted write data
- mem_wmask  out  4  granted write mask; 0 when idle or reading
- mem_rdata  in  32  memory read data

## Operation
- Grant selection is combinational from the req inputs, lock state and RR pointer. At most one mN_gnt is high per cycle.
- Memory outputs are a combinational mux of the granted master's fields:
  - mem_rstrb = gnt & !we
  - mem_wmask = gnt & we ? wmask : 0
- Round-robin pointer:
  - Points to the master favored on the next contention.
  - After a grant to master k, the pointer moves to the other master.
  - A single requester is granted every cycle regardless of the pointer.
- PRIO_MODE=1: master 0 wins every contention; the pointer is ignored.
- Lock FSM states: UNLOCKED, LOCK0, LOCK1.
  - UNLOCKED to LOCKk: on a grant to k with mk_lock=1.
  - LOCKk: only master k may be granted; the other master's req waits with no gnt.
  - LOCKk to UNLOCKED: on a grant to k with mk_lock=0, or in any cycle where mk_req=0 and mk_lock=0.
  - The RR pointer does not advance while LOCKk is held.
- Read return tracking:
  - A shift register of depth RD_LAT carries {valid, master id} per granted read.
  - When a tag exits, it asserts the matching mN_rvalid and routes mem_rdata to that master's mN_rdata.
  - The other master's rdata holds its last value.
- Writes produce no response. A write is complete in its grant cycle.

## Timing
- Grant latency: 0 cycles. gnt rises in the same cycle as req when the master wins.
- Read data: mN_rvalid asserts exactly RD_LAT cycles after the grant cycle.
- Throughput: one command per cycle, fully pipelined. A new grant may coincide with an rvalid from an earlier read.
- Both masters requesting with the pointer at m1 in RR mode: m1 is granted this cycle, m0 the next.
- Reset values:
  - mN_gnt=0, mN_rvalid=0, mN_rdata=0
  - mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0
  - Lock FSM = UNLOCKED, RR pointer = master 0, tag pipeline cleared
- Reset mid-read: in-flight tags are discarded, so no rvalid appears after reset.
- All grants are gated off while reset=1.
- Req dropped before gnt: legal. The command is abandoned with no side effects.
- mN_req=1 with we=0 while the same master's rvalid is pending: legal. Tags keep responses ordered.

## Structure
- Shared package riscv_bus_pkg: master-id constants (M_CPU=0, M_AUX=1), PRIO_MODE encodings, lock-state enum.
- One sub-module: bus_rr_pick, a 2-way grant picker taking req, pointer, lock state and mode, and producing a one-hot grant.
- The tag pipeline and output muxing stay in the top module.

## Test plan
- m0 read addr 0x10 alone, RD_LAT=1 -> m0_gnt same cycle, mem_rstrb=1, mem_addr=0x10; m0_rvalid next cycle with m0_rdata equal to the memory word at 0x10.
- Both masters hold req for 4 cycles, RR mode, after reset -> grants alternate m0, m1, m0, m1.
- Same stimulus with PRIO_MODE=1 -> m0 granted 4 times, m1_gnt stays 0 until m0_req drops.
- m1 locked read at 0x20, then m1 write with lock=0 two cycles later, while m0 requests continuously -> m0 gets no grant until after m1's unlocking write; the write lands with the given mask.
- RD_LAT=3, m0 read then m1 read on consecutive cycles -> m0_rvalid at cycle +3 and m1_rvalid at +4, each with the correct word.
- Reset asserted one cycle after a granted read, RD_LAT=2 -> no rvalid on either master; all outputs 0 during reset.
